// File: rtl/hard_png_pixel_fifo.sv
// Pixel FIFO behind hard_png: valid/ready pixel stream with frame tags and input throttling.
// Optional stall statistics counter enabled by HARD_PNG_PIXEL_FIFO_STATS_EN.
module hard_png_pixel_fifo #(
    parameter int DEPTH_LOG2 = 10,
    parameter int AF_MARGIN  = 64
) (
    input  logic        rstn,
    input  logic        clk,
    input  logic        s_ivalid,
    output logic        s_iready,
    input  logic [7:0]  s_ibyte,
    output logic        d_ivalid,
    input  logic        d_iready,
    output logic [7:0]  d_ibyte,
    input  logic        newframe,
    input  logic [13:0] width,
    input  logic [31:0] height,
    input  logic        ovalid,
    input  logic [7:0]  opixelr,
    input  logic [7:0]  opixelg,
    input  logic [7:0]  opixelb,
    input  logic [7:0]  opixela,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_data,
    output logic        m_sof,
    output logic        m_eol,
    output logic        m_eof,
    output logic        frame_done,
    output logic [1:0]  err,
    output logic [31:0] stall_cnt
);

    localparam int CNT_W = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_LVL = CNT_W'(AF_MARGIN);

    logic [34:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr, rptr, raddr;
    logic [CNT_W-1:0]      count, free_cnt;
    logic                  af, full, push, pop, vld_n;
    logic [34:0]           out_q;
    logic                  out_vld;

    logic [13:0] w_q, x_q, w_cur, x_cur, x_n;
    logic [31:0] h_q, y_q, h_cur, y_cur, y_n;
    logic        no_pix, advance, ovf, extra;
    logic        tag_sof, tag_eol, tag_eof;

    // throttle decision only looks at the registered occupancy
    assign free_cnt = FULL_CNT - count;
    assign af       = free_cnt < AF_LVL;
    assign full     = count == FULL_CNT;

    assign d_ibyte  = s_ibyte;
    assign d_ivalid = s_ivalid & ~af;
    assign s_iready = d_iready & ~af;

    always_comb begin
        w_cur   = newframe ? width  : w_q;
        h_cur   = newframe ? height : h_q;
        x_cur   = newframe ? 14'd0  : x_q;
        y_cur   = newframe ? 32'd0  : y_q;
        no_pix  = (w_cur == 14'd0) || (h_cur == 32'd0) || (y_cur >= h_cur);
        tag_sof = (x_cur == 14'd0) && (y_cur == 32'd0);
        tag_eol = x_cur == (w_cur - 14'd1);
        tag_eof = tag_eol && (y_cur == (h_cur - 32'd1));
        advance = ovalid && !no_pix;
        push    = advance && !full;
        ovf     = advance && full;
        extra   = ovalid && no_pix;
        x_n     = x_cur;
        y_n     = y_cur;
        if (advance) begin
            if (tag_eol) begin
                x_n = 14'd0;
                y_n = y_cur + 32'd1;
            end else begin
                x_n = x_cur + 14'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_q        <= '0;
            h_q        <= '0;
            x_q        <= '0;
            y_q        <= '0;
            err        <= '0;
            frame_done <= 1'b0;
        end else begin
            if (newframe) begin
                w_q <= width;
                h_q <= height;
            end
            x_q        <= x_n;
            y_q        <= y_n;
            err        <= (newframe ? 2'b00 : err) | {extra, ovf};
            frame_done <= push && tag_eof;
        end
    end

    // the output register prefetches the entry behind the one being popped
    assign pop   = out_vld && m_ready;
    assign raddr = rptr + DEPTH_LOG2'(pop);
    assign vld_n = (count - CNT_W'(pop)) != '0;

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= {opixelr, opixelg, opixelb, opixela,
                          tag_sof, tag_eol, tag_eof};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            out_vld <= 1'b0;
            out_q   <= '0;
        end else begin
            if (push)
                wptr <= wptr + DEPTH_LOG2'(1);
            if (pop)
                rptr <= rptr + DEPTH_LOG2'(1);
            count   <= count + CNT_W'(push) - CNT_W'(pop);
            out_vld <= vld_n;
            if (vld_n)
                out_q <= mem[raddr];
        end
    end

    assign m_valid = out_vld;
    assign m_data  = out_q[34:3];
    assign m_sof   = out_vld & out_q[2];
    assign m_eol   = out_vld & out_q[1];
    assign m_eof   = out_vld & out_q[0];

`ifdef HARD_PNG_PIXEL_FIFO_STATS_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            stall_q <= '0;
        else if (newframe)
            stall_q <= '0;
        else if (s_ivalid && d_iready && af && (stall_q != 32'hFFFF_FFFF))
            stall_q <= stall_q + 32'd1;
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hard_png_pixel_fifo.sv
// Randomised bench for hard_png_pixel_fifo against a queue-based frame model.
// Small FIFO (16 deep, margin 4) so throttling and overflow are reachable.
module tb_hard_png_pixel_fifo;

    localparam int DL    = 4;
    localparam int DEPTH = 16;
    localparam int AFM   = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        s_ivalid, s_iready, d_ivalid, d_iready;
    logic [7:0]  s_ibyte, d_ibyte;
    logic        newframe;
    logic [13:0] width;
    logic [31:0] height;
    logic        ovalid;
    logic [7:0]  opixelr, opixelg, opixelb, opixela;
    logic        m_valid, m_ready;
    logic [31:0] m_data;
    logic        m_sof, m_eol, m_eof, frame_done;
    logic [1:0]  err;
    logic [31:0] stall_cnt;

    always #5 clk = ~clk;

    hard_png_pixel_fifo #(.DEPTH_LOG2(DL), .AF_MARGIN(AFM)) dut (
        .rstn(rstn), .clk(clk),
        .s_ivalid(s_ivalid), .s_iready(s_iready), .s_ibyte(s_ibyte),
        .d_ivalid(d_ivalid), .d_iready(d_iready), .d_ibyte(d_ibyte),
        .newframe(newframe), .width(width), .height(height),
        .ovalid(ovalid), .opixelr(opixelr), .opixelg(opixelg),
        .opixelb(opixelb), .opixela(opixela),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof),
        .frame_done(frame_done), .err(err), .stall_cnt(stall_cnt)
    );

    // reference model: queue of stored pixels {data, sof, eol, eof}
    logic [34:0]     mq[$];
    int unsigned     fw, fh, fn, stall_exp;
    longint unsigned ftot;
    logic [1:0]      merr;
    bit              fd_pend;
    int              checks = 0;
    int              errors = 0;

    bit          st_pop, st_qe, st_fd_got, st_fd_exp;
    logic [34:0] st_got, st_exp;

    function automatic bit model_af();
        return (DEPTH - mq.size()) < AFM;
    endfunction

    task automatic reset_model();
        mq.delete();
        fw = 0; fh = 0; fn = 0; stall_exp = 0;
        merr = 2'b00; fd_pend = 1'b0;
    endtask

    // one clock: drive, capture handshake, advance model, wait for edge
    task automatic step(input bit ov, input bit nf, input logic [13:0] w,
                        input logic [31:0] h, input bit mr);
        int sz;
        int unsigned x;
        logic [31:0] pix;
        pix = $urandom;
        ovalid = ov; newframe = nf; width = w; height = h;
        {opixelr, opixelg, opixelb, opixela} = pix;
        m_ready = mr;
        s_ibyte = 8'($urandom);
        #1;
        st_pop = m_valid && mr;
        st_got = {m_data, m_sof, m_eol, m_eof};
        st_qe = mq.size() == 0;
        st_exp = st_qe ? 35'd0 : mq[0];
        st_fd_got = frame_done;
        st_fd_exp = fd_pend;
        sz = mq.size();
        if (nf) stall_exp = 0;
        else if (s_ivalid && d_iready && (DEPTH - sz) < AFM) stall_exp++;
        if (nf) begin
            fw = w; fh = h; fn = 0; merr = 2'b00;
        end
        fd_pend = 1'b0;
        if (st_pop && !st_qe) void'(mq.pop_front());
        if (ov) begin
            ftot = longint'(fw) * longint'(fh);
            if (ftot == 0 || fn >= ftot) begin
                merr[1] = 1'b1;
            end else begin
                x = fn % fw;
                if (sz >= DEPTH) begin
                    merr[0] = 1'b1;
                end else begin
                    mq.push_back({pix, fn == 0, x == fw - 1, longint'(fn) == ftot - 1});
                    fd_pend = longint'(fn) == ftot - 1;
                end
                fn++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; s_ivalid = 1'b0; d_iready = 1'b1; s_ibyte = 8'd0;
        newframe = 1'b0; width = '0; height = '0; ovalid = 1'b0;
        {opixelr, opixelg, opixelb, opixela} = 32'd0; m_ready = 1'b0;
        reset_model();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_mvalid got %b want 0", m_valid); end
        checks++;
        if ({m_sof, m_eol, m_eof, frame_done} !== 4'b0) begin
            errors++; $display("FAIL rst_tags got %b want 0000", {m_sof, m_eol, m_eof, frame_done});
        end
        checks++;
        if (err !== 2'b00) begin errors++; $display("FAIL rst_err got %b want 00", err); end
        checks++;
        if (stall_cnt !== 32'd0) begin errors++; $display("FAIL rst_stall got %0d want 0", stall_cnt); end
        rstn = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (s_iready !== 1'b1) begin errors++; $display("FAIL rst_iready got %b want 1", s_iready); end
    endtask

    task automatic test_basic();
        int npop = 0, nfd = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, i == 0, 14'd4, 32'd2, 1'b1);
            if (st_pop) begin
                npop++; checks++;
                if (st_qe || st_got !== st_exp) begin
                    errors++; $display("FAIL basic_pix got %h want %h", st_got, st_exp);
                end
            end
            nfd += int'(st_fd_got);
            if (i == 0) begin
                checks++;
                if (m_valid !== 1'b0) begin errors++; $display("FAIL lat_n1 got %b want 0", m_valid); end
            end
            if (i == 1) begin
                checks++;
                if (m_valid !== 1'b1) begin errors++; $display("FAIL lat_n2 got %b want 1", m_valid); end
            end
        end
        for (int c = 0; c < 30 && (mq.size() != 0 || fd_pend); c++) begin
            step(1'b0, 1'b0, 14'd0, 32'd0, 1'b1);
            if (st_pop) begin
                npop++; checks++;
                if (st_qe || st_got !== st_exp) begin
                    errors++; $display("FAIL basic_pix got %h want %h", st_got, st_exp);
                end
            end
            nfd += int'(st_fd_got);
            checks++;
            if (st_fd_got !== st_fd_exp) begin
                errors++; $display("FAIL basic_fd got %b want %b", st_fd_got, st_fd_exp);
            end
        end
        checks++;
        if (npop != 8) begin errors++; $display("FAIL basic_count got %0d want 8", npop); end
        checks++;
        if (nfd != 1) begin errors++; $display("FAIL basic_fdcnt got %0d want 1", nfd); end
        checks++;
        if (err !== merr) begin errors++; $display("FAIL basic_err got %b want %b", err, merr); end
    endtask

    task automatic test_overflow();
        int npop = 0;
        bit exp_af;
        s_ivalid = 1'b0;
        step(1'b0, 1'b1, 14'd64, 32'd1, 1'b0);
        for (int i = 1; i <= 17; i++) begin
            step(1'b1, 1'b0, 14'd0, 32'd0, 1'b0);
            exp_af = model_af();
            checks++;
            if (s_iready !== !exp_af) begin
                errors++; $display("FAIL ovf_iready n=%0d got %b want %b", i, s_iready, !exp_af);
            end
        end
        checks++;
        if (err !== merr) begin errors++; $display("FAIL ovf_err got %b want %b", err, merr); end
        s_ivalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 14'd0, 32'd0, 1'b0);
            checks++;
            if (d_ivalid !== (s_ivalid && !model_af()) || d_ibyte !== s_ibyte) begin
                errors++; $display("FAIL thr_dvalid got %b/%h want %b/%h",
                                   d_ivalid, d_ibyte, s_ivalid && !model_af(), s_ibyte);
            end
        end
`ifdef HARD_PNG_PIXEL_FIFO_STATS_EN
        checks++;
        if (stall_cnt !== stall_exp) begin
            errors++; $display("FAIL stall_cnt got %0d want %0d", stall_cnt, stall_exp);
        end
`else
        checks++;
        if (stall_cnt !== 32'd0) begin errors++; $display("FAIL stall_off got %0d want 0", stall_cnt); end
`endif
        s_ivalid = 1'b0;
        for (int c = 0; c < 40 && mq.size() != 0; c++) begin
            step(1'b0, 1'b0, 14'd0, 32'd0, 1'b1);
            if (st_pop) begin
                npop++; checks++;
                if (st_qe || st_got !== st_exp) begin
                    errors++; $display("FAIL ovf_pix got %h want %h", st_got, st_exp);
                end
            end
        end
        step(1'b0, 1'b0, 14'd0, 32'd0, 1'b1);
        checks++;
        if (npop != 16 || m_valid !== 1'b0) begin
            errors++; $display("FAIL ovf_drain got %0d/%b want 16/0", npop, m_valid);
        end
    endtask

    task automatic test_extra();
        int nfd = 0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, i == 0, 14'd2, 32'd1, 1'b1);
            nfd += int'(st_fd_got);
        end
        checks++;
        if (err !== merr || err !== 2'b10) begin
            errors++; $display("FAIL extra_err got %b want %b", err, merr);
        end
        for (int c = 0; c < 10; c++) begin
            step(1'b0, 1'b0, 14'd0, 32'd0, 1'b1);
            nfd += int'(st_fd_got);
            if (st_pop) begin
                checks++;
                if (st_qe || st_got !== st_exp) begin
                    errors++; $display("FAIL extra_pix got %h want %h", st_got, st_exp);
                end
            end
        end
        checks++;
        if (nfd != 1 || mq.size() != 0) begin
            errors++; $display("FAIL extra_fd got %0d want 1", nfd);
        end
        step(1'b0, 1'b1, 14'd2, 32'd1, 1'b1);
        checks++;
        if (err !== merr) begin errors++; $display("FAIL extra_clr got %b want %b", err, merr); end
    endtask

    task automatic test_zero();
        step(1'b0, 1'b1, 14'd0, 32'd5, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 14'd0, 32'd0, 1'b1);
            checks++;
            if (m_valid !== 1'b0) begin errors++; $display("FAIL zero_mvalid got %b want 0", m_valid); end
        end
        checks++;
        if (err !== merr) begin errors++; $display("FAIL zero_err got %b want %b", err, merr); end
    endtask

    task automatic test_random();
        int sent = 0, npop = 0, nfd = 0;
        bit ov;
        step(1'b0, 1'b1, 14'd10, 32'd100, 1'b1);
        for (int c = 0; c < 20000 && (sent < 1000 || mq.size() != 0 || fd_pend); c++) begin
            ov = (sent < 1000) && s_iready && ($urandom_range(3) != 0);
            step(ov, 1'b0, 14'd0, 32'd0, 1'($urandom_range(1)));
            sent += int'(ov);
            nfd += int'(st_fd_got);
            if (st_pop) begin
                npop++; checks++;
                if (st_qe || st_got !== st_exp) begin
                    errors++; $display("FAIL rand_pix n=%0d got %h want %h", npop, st_got, st_exp);
                end
            end
        end
        checks++;
        if (npop != 1000) begin errors++; $display("FAIL rand_count got %0d want 1000", npop); end
        checks++;
        if (nfd != 1 || err !== merr) begin
            errors++; $display("FAIL rand_end got fd=%0d err=%b want 1/%b", nfd, err, merr);
        end
    endtask

    task automatic test_reset_mid();
        int npop = 0;
        step(1'b0, 1'b1, 14'd8, 32'd8, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 14'd0, 32'd0, 1'b0);
        step(1'b0, 1'b0, 14'd0, 32'd0, 1'b0);
        checks++;
        if (m_valid !== 1'b1) begin errors++; $display("FAIL mid_pre got %b want 1", m_valid); end
        #1 rstn = 1'b0;
        #1;
        checks++;
        if (m_valid !== 1'b0 || err !== 2'b00) begin
            errors++; $display("FAIL mid_async got %b/%b want 0/00", m_valid, err);
        end
        @(posedge clk);
        #1 rstn = 1'b1;
        reset_model();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 14'd0, 32'd0, 1'b1);
            checks++;
            if (m_valid !== 1'b0) begin errors++; $display("FAIL mid_empty got %b want 0", m_valid); end
        end
        checks++;
        if (stall_cnt !== 32'd0 || err !== 2'b00) begin
            errors++; $display("FAIL mid_clr got %0d/%b want 0/00", stall_cnt, err);
        end
        step(1'b1, 1'b1, 14'd1, 32'd1, 1'b1);
        for (int c = 0; c < 6; c++) begin
            step(1'b0, 1'b0, 14'd0, 32'd0, 1'b1);
            if (st_pop) begin
                npop++; checks++;
                if (st_qe || st_got !== st_exp) begin
                    errors++; $display("FAIL mid_pix got %h want %h", st_got, st_exp);
                end
            end
        end
        checks++;
        if (npop != 1) begin errors++; $display("FAIL mid_count got %0d want 1", npop); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_extra();
        test_zero();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
